// File: rtl/term_cursor_ctrl_pkg.sv
// Shared geometry, command codes and types for the terminal cursor front end.
package term_cursor_ctrl_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = COL_W + ROW_W;

    localparam logic [COL_W-1:0] MAXCOL = 7'd79;
    localparam logic [ROW_W-1:0] MAXROW = 5'd31;

    localparam logic [CODE_W-1:0] CMD_SPC   = 7'h20;
    localparam logic [CODE_W-1:0] CMD_CR    = 7'h0D;
    localparam logic [CODE_W-1:0] CMD_LF    = 7'h0A;
    localparam logic [CODE_W-1:0] CMD_BS    = 7'h08;
    localparam logic [CODE_W-1:0] CMD_FF    = 7'h0C;
    localparam logic [CODE_W-1:0] CMD_EOL   = 7'h0B;
    localparam logic [CODE_W-1:0] CHAR_LAST = 7'h7E;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        ARM,
        FIRE,
        WAIT
    } state_t;

    // Character RAM address: column in the upper bits, physical row below
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } bufAddr_t;

    function automatic logic isPrintable(input logic [CODE_W-1:0] code);
        return (code >= CMD_SPC) && (code <= CHAR_LAST);
    endfunction

endpackage

// File: rtl/term_cursor_ctrl_if.sv
// Keyboard-decoder to cursor-controller code handshake.
interface term_cursor_ctrl_if;
    import term_cursor_ctrl_pkg::*;

    logic              charValid;
    logic [CODE_W-1:0] charData;
    logic              charReady;

    modport master (output charValid, output charData, input charReady);
    modport slave  (input charValid, input charData, output charReady);
endinterface

// File: rtl/term_cursor_ctrl.sv
// Terminal front end: tracks cursor/scroll, writes characters to the buffer and
// sequences the clear engine for full clears, end-of-line and scroll erases.
module term_cursor_ctrl
    import term_cursor_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    term_cursor_ctrl_if.slave kbd,
    input  logic              initBusy,
    output logic              clrEnable,
    output logic              partLineInit,
    output logic [ROW_W-1:0]  partLineRow,
    output logic [COL_W-1:0]  partLineCol,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddress,
    output logic [CODE_W-1:0] wrData,
    output logic [COL_W-1:0]  cursorCol,
    output logic [ROW_W-1:0]  cursorRow,
    output logic [ROW_W-1:0]  scrollRow
);

    state_t            state;
    state_t            stateNext;
    logic [CODE_W-1:0] codeReg;
    logic [ROW_W-1:0]  physRow;
    logic              accept;

    logic              wrHit;
    bufAddr_t          wrAddrNext;
    logic [CODE_W-1:0] wrDataNext;

    logic [COL_W-1:0]  colNext;
    logic [ROW_W-1:0]  rowNext;
    logic [ROW_W-1:0]  scrollNext;
    logic              doNewline;
    logic              eraseReq;
    logic              erasePart;
    logic [ROW_W-1:0]  eraseRow;
    logic [COL_W-1:0]  eraseCol;

    assign physRow = scrollRow + cursorRow;
    assign accept  = (state == IDLE) && kbd.charValid;

    // Buffer write decided at accept time so wrEn lands exactly in EXEC
    always_comb begin
        wrHit      = 1'b0;
        wrAddrNext = '{col: cursorCol, row: physRow};
        wrDataNext = kbd.charData;
        if (isPrintable(kbd.charData)) begin
            wrHit = 1'b1;
        end else if ((kbd.charData == CMD_BS) && (cursorCol != '0)) begin
            wrHit          = 1'b1;
            wrAddrNext.col = cursorCol - COL_W'(1);
            wrDataNext     = CMD_SPC;
        end
    end

    // EXEC decode: cursor/scroll update and erase request
    always_comb begin
        colNext    = cursorCol;
        rowNext    = cursorRow;
        scrollNext = scrollRow;
        doNewline  = 1'b0;
        eraseReq   = 1'b0;
        erasePart  = 1'b0;
        eraseRow   = '0;
        eraseCol   = '0;
        if (isPrintable(codeReg)) begin
            if (cursorCol == MAXCOL) begin
                colNext   = '0;
                doNewline = 1'b1;
            end else begin
                colNext = cursorCol + COL_W'(1);
            end
        end else begin
            case (codeReg)
                CMD_CR:  colNext = '0;
                CMD_LF:  doNewline = 1'b1;
                CMD_BS:  if (cursorCol != '0) colNext = cursorCol - COL_W'(1);
                CMD_FF: begin
                    colNext    = '0;
                    rowNext    = '0;
                    scrollNext = '0;
                    eraseReq   = 1'b1;
                end
                CMD_EOL: begin
                    eraseReq  = 1'b1;
                    erasePart = 1'b1;
                    eraseRow  = physRow;
                    eraseCol  = cursorCol;
                end
                default: ;
            endcase
        end
        // Scrolling exposes the old top row as the new bottom row; blank it
        if (doNewline) begin
            if (cursorRow != MAXROW) begin
                rowNext = cursorRow + ROW_W'(1);
            end else begin
                scrollNext = scrollRow + ROW_W'(1);
                eraseReq   = 1'b1;
                erasePart  = 1'b1;
                eraseRow   = scrollRow;
                eraseCol   = '0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (kbd.charValid) stateNext = EXEC;
            EXEC: stateNext = eraseReq ? ARM : IDLE;
            // Out of reset clrEnable is still low: hold ARM one cycle to raise it
            ARM:  stateNext = clrEnable ? FIRE : ARM;
            FIRE: stateNext = WAIT;
            WAIT: if (!initBusy) stateNext = IDLE;
            default: stateNext = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ARM;
        else         state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            kbd.charReady <= 1'b0;
            clrEnable     <= 1'b0;
            partLineInit  <= 1'b0;
            partLineRow   <= '0;
            partLineCol   <= '0;
            wrEn          <= 1'b0;
            wrAddress     <= '0;
            wrData        <= '0;
            codeReg       <= '0;
            cursorCol     <= '0;
            cursorRow     <= '0;
            scrollRow     <= '0;
        end else begin
            kbd.charReady <= (stateNext == IDLE);
            clrEnable     <= (stateNext == ARM);
            wrEn          <= accept && wrHit;
            if (accept) begin
                codeReg   <= kbd.charData;
                wrAddress <= wrAddrNext;
                wrData    <= wrDataNext;
            end
            if (state == EXEC) begin
                cursorCol <= colNext;
                cursorRow <= rowNext;
                scrollRow <= scrollNext;
                if (eraseReq) begin
                    partLineInit <= erasePart;
                    partLineRow  <= eraseRow;
                    partLineCol  <= eraseCol;
                end
            end
            if (stateNext == WAIT) begin
                partLineInit <= 1'b0;
                partLineRow  <= '0;
                partLineCol  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Bench for term_cursor_ctrl: clear-engine model plus a cursor/scroll reference model.
module tb_term_cursor_ctrl;

    logic        clk;
    logic        resetn;
    logic        initBusy;
    logic        clrEnable;
    logic        partLineInit;
    logic [4:0]  partLineRow;
    logic [6:0]  partLineCol;
    logic        wrEn;
    logic [11:0] wrAddress;
    logic [6:0]  wrData;
    logic [6:0]  cursorCol;
    logic [4:0]  cursorRow;
    logic [4:0]  scrollRow;

    int total = 0;
    int bad   = 0;

    int mCol    = 0;
    int mRow    = 0;
    int mScroll = 0;

    int busyCnt;
    logic clrPrev;

    term_cursor_ctrl_if kbd ();

    term_cursor_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .kbd         (kbd),
        .initBusy    (initBusy),
        .clrEnable   (clrEnable),
        .partLineInit(partLineInit),
        .partLineRow (partLineRow),
        .partLineCol (partLineCol),
        .wrEn        (wrEn),
        .wrAddress   (wrAddress),
        .wrData      (wrData),
        .cursorCol   (cursorCol),
        .cursorRow   (cursorRow),
        .scrollRow   (scrollRow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear engine: starts on clrEnable falling edge, busy for the erase length
    always @(posedge clk) begin
        if (!resetn) begin
            busyCnt <= 0;
            clrPrev <= 1'b0;
        end else begin
            clrPrev <= clrEnable;
            if (clrPrev && !clrEnable)
                busyCnt <= partLineInit ? (80 - int'(partLineCol)) : 2560;
            else if (busyCnt != 0)
                busyCnt <= busyCnt - 1;
        end
    end
    assign initBusy = (busyCnt != 0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for charReady from a FIRE-cycle sample and check erase length
    task automatic waitErase(input int expBusy);
        int cyc;
        int busyN;
        cyc   = 0;
        busyN = 0;
        while (kbd.charReady !== 1'b1 && cyc < 3000) begin
            step();
            cyc++;
            if (initBusy === 1'b1) busyN++;
        end
        chk("eraseToReady", 64'(cyc), 64'(expBusy + 2));
        chk("eraseBusyLen", 64'(busyN), 64'(expBusy));
        chk("partDeassert", {partLineInit, partLineRow, partLineCol}, 64'd0);
    endtask

    task automatic powerOn();
        resetn        = 1'b0;
        kbd.charValid = 1'b0;
        kbd.charData  = '0;
        repeat (3) step();
        chk("rstClr", clrEnable, 0);
        chk("rstReady", kbd.charReady, 0);
        chk("rstWrEn", wrEn, 0);
        chk("rstCursor", {cursorCol, cursorRow, scrollRow}, 0);
        chk("rstPart", {partLineInit, partLineRow, partLineCol}, 0);
        chk("rstWrBus", {wrAddress, wrData}, 0);
        resetn = 1'b1;
        step();
        chk("porClrHigh", clrEnable, 1);
        chk("porFullClear", partLineInit, 0);
        chk("porNotReady", kbd.charReady, 0);
        step();
        chk("porClrLow", clrEnable, 0);
        waitErase(2560);
        chk("porCursor", {cursorCol, cursorRow, scrollRow}, 0);
        mCol    = 0;
        mRow    = 0;
        mScroll = 0;
    endtask

    task automatic doCode(input logic [6:0] code);
        int expWr, expCol, expRow, expData;
        int eraseKind, eRow, eCol;
        int phys, cyc, ci;
        logic nl;
        ci        = int'(code);
        phys      = (mScroll + mRow) % 32;
        expWr     = 0;
        expCol    = 0;
        expRow    = 0;
        expData   = 0;
        eraseKind = 0;
        eRow      = 0;
        eCol      = 0;
        nl        = 1'b0;
        if (ci >= 32 && ci <= 126) begin
            expWr = 1; expCol = mCol; expRow = phys; expData = ci;
            if (mCol == 79) begin mCol = 0; nl = 1'b1; end
            else mCol++;
        end else if (ci == 13) mCol = 0;
        else if (ci == 10) nl = 1'b1;
        else if (ci == 8) begin
            if (mCol > 0) begin
                mCol--;
                expWr = 1; expCol = mCol; expRow = phys; expData = 32;
            end
        end else if (ci == 12) begin
            mCol = 0; mRow = 0; mScroll = 0; eraseKind = 1;
        end else if (ci == 11) begin
            eraseKind = 2; eRow = phys; eCol = mCol;
        end
        if (nl) begin
            if (mRow < 31) mRow++;
            else begin
                eraseKind = 2; eRow = mScroll; eCol = 0;
                mScroll = (mScroll + 1) % 32;
            end
        end

        cyc = 0;
        while (kbd.charReady !== 1'b1 && cyc < 5000) begin step(); cyc++; end
        chk("readyBeforeSend", kbd.charReady, 1);
        kbd.charValid = 1'b1;
        kbd.charData  = code;
        step();
        kbd.charValid = 1'b0;
        chk("execWrEn", wrEn, 64'(expWr));
        chk("execNotReady", kbd.charReady, 0);
        if (expWr == 1) begin
            chk("wrAddress", wrAddress, {7'(expCol), 5'(expRow)});
            chk("wrData", wrData, 64'(expData));
        end
        step();
        chk("wrEnOneCycle", wrEn, 0);
        chk("cursorCol", cursorCol, 64'(mCol));
        chk("cursorRow", cursorRow, 64'(mRow));
        chk("scrollRow", scrollRow, 64'(mScroll));
        if (eraseKind == 0) begin
            chk("readyNoErase", kbd.charReady, 1);
            chk("noClr", clrEnable, 0);
        end else begin
            chk("armClr", clrEnable, 1);
            chk("armPartInit", partLineInit, 64'(eraseKind == 2));
            chk("armPartPos", {partLineRow, partLineCol}, {5'(eRow), 7'(eCol)});
            step();
            chk("fireClr", clrEnable, 0);
            chk("firePartHold", {partLineInit, partLineRow, partLineCol},
                {1'(eraseKind == 2), 5'(eRow), 7'(eCol)});
            waitErase(eraseKind == 2 ? 80 - eCol : 2560);
            chk("cursorAfterErase", {cursorCol, cursorRow, scrollRow},
                {7'(mCol), 5'(mRow), 5'(mScroll)});
        end
    endtask

    function automatic logic [6:0] randCode();
        int r;
        int o;
        r = int'($urandom_range(0, 99));
        if (r < 60) return 7'($urandom_range(32, 126));
        if (r < 70) return 7'h0D;
        if (r < 80) return 7'h0A;
        if (r < 88) return 7'h08;
        if (r < 95) return 7'h0B;
        if (r < 96) return 7'h0C;
        o = int'($urandom_range(0, 31));
        if (o == 8 || o == 10 || o == 11 || o == 12 || o == 13) o = 127;
        return 7'(o);
    endfunction

    initial begin
        resetn        = 1'b0;
        kbd.charValid = 1'b0;
        kbd.charData  = '0;
        powerOn();

        // Cursor to (5,2), then 'A'
        doCode(7'h0A);
        doCode(7'h0A);
        for (int i = 0; i < 5; i++) doCode(7'h61 + 7'(i));
        doCode(7'h41);

        // Backspace at column 0 and at column 10 on row 7
        for (int i = 0; i < 5; i++) doCode(7'h0A);
        doCode(7'h0D);
        doCode(7'h08);
        for (int i = 0; i < 10; i++) doCode(7'h30 + 7'(i));
        doCode(7'h08);

        // Scroll to 3 with cursor on row 31, EOL at col 70, then wrap at col 79
        doCode(7'h0C);
        for (int i = 0; i < 34; i++) doCode(7'h0A);
        for (int i = 0; i < 70; i++) doCode(7'h2E);
        doCode(7'h0B);
        for (int i = 0; i < 9; i++) doCode(7'h2D);
        doCode(7'h5A);

        for (int i = 0; i < 80; i++) doCode(randCode());

        // Reset in the middle of a full clear
        begin
            int cyc;
            cyc = 0;
            while (kbd.charReady !== 1'b1 && cyc < 5000) begin step(); cyc++; end
            kbd.charValid = 1'b1;
            kbd.charData  = 7'h0C;
            step();
            kbd.charValid = 1'b0;
            repeat (100) step();
            chk("midClearBusy", kbd.charReady, 0);
        end
        powerOn();

        for (int i = 0; i < 20; i++) doCode(randCode());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
